fw_rule_lookup: RTL and testbench

- Sequencer that owns the SRAM read port for the firewall datapath and scans a rule table held in SRAM.
- The packet parser hands it a {dst IP, dst TCP port} key. The block reads rule words one at a time over the rd_0 request/ack/valid handshake and compares each against the key.
- It returns a single pass/drop verdict.
- It sits between the header-parsing stage and the SRAM controller. It is the only master on rd_0.

---
 rtl/fw_pkg.sv | 27 ++
 rtl/fw_rule_match.sv | 41 ++++
 rtl/fw_rule_lookup.sv | 169 ++++++++++++++++
 tb/tb_fw_rule_lookup.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fw_pkg.sv
// ============================================================================
// fw_pkg: firewall rule word layout and lookup sequencer state encodings.
// Revision: 1.0
// ============================================================================
`default_nettype none

package fw_pkg;

    localparam int VALID_BIT  = 63;
    localparam int ACTION_BIT = 62;
    localparam int PORT_HI    = 47;
    localparam int PORT_LO    = 32;
    localparam int IP_HI      = 31;
    localparam int IP_LO      = 0;

    localparam logic ACTION_DROP = 1'b1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_VLD = 2'd2,
        DONE     = 2'd3
    } state_e;

endpackage

`default_nettype wire

// File: rtl/fw_rule_match.sv
// ============================================================================
// fw_rule_match: compares one rule word against a {dst IP, dst port} key.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fw_rule_match
    import fw_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic [DATA_WIDTH-1:0] rule_i,
    input  logic [31:0]           key_ip_i,
    input  logic [15:0]           key_port_i,
    output logic                  match_o,
    output logic                  valid_o,
    output logic                  action_o
);

    logic [31:0] w_rule_ip;
    logic [15:0] w_rule_port;
    logic        w_ip_ok;
    logic        w_port_ok;
    logic        w_unused_reserved;

    assign w_rule_ip   = rule_i[IP_HI:IP_LO];
    assign w_rule_port = rule_i[PORT_HI:PORT_LO];

    // A zero field in the rule acts as a wildcard.
    assign w_ip_ok   = (w_rule_ip == 32'd0) || (w_rule_ip == key_ip_i);
    assign w_port_ok = (w_rule_port == 16'd0) || (w_rule_port == key_port_i);

    assign valid_o  = rule_i[VALID_BIT];
    assign action_o = rule_i[ACTION_BIT];
    assign match_o  = valid_o && w_ip_ok && w_port_ok;

    assign w_unused_reserved = ^rule_i[61:48];

endmodule

`default_nettype wire

// File: rtl/fw_rule_lookup.sv
// ============================================================================
// fw_rule_lookup: scans the SRAM rule table over rd_0 and returns a verdict.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fw_rule_lookup
    import fw_pkg::*;
#(
    parameter int                         DATA_WIDTH      = 64,
    parameter int                         SRAM_ADDR_WIDTH = 19,
    parameter logic [SRAM_ADDR_WIDTH-1:0] RULE_BASE       = 19'h0,
    parameter int                         NUM_RULES       = 5,
    parameter int                         TIMEOUT_CYCLES  = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         lookup_req,
    input  logic [31:0]                  lookup_ip,
    input  logic [15:0]                  lookup_port,
    output logic                         lookup_rdy,
    output logic                         result_vld,
    output logic                         result_drop,
    output logic                         result_hit,
    output logic [$clog2(NUM_RULES):0]   result_idx,
    output logic                         result_timeout,
    output logic                         rd_0_req,
    output logic [SRAM_ADDR_WIDTH-1:0]   rd_0_addr,
    input  logic                         rd_0_ack,
    input  logic [DATA_WIDTH-1:0]        rd_0_data,
    input  logic                         rd_0_vld
);

    localparam int IDX_W = $clog2(NUM_RULES) + 1;
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

    state_e                       state_q;
    logic [31:0]                  key_ip_q;
    logic [15:0]                  key_port_q;
    logic [IDX_W-1:0]             index_q;
    logic [WD_W-1:0]              wd_q;
    logic                         rdy_q;
    logic                         req_q;
    logic [SRAM_ADDR_WIDTH-1:0]   addr_q;
    logic                         v_drop_q, v_hit_q, v_to_q;
    logic [IDX_W-1:0]             v_idx_q;
    logic                         res_vld_q, res_drop_q, res_hit_q, res_to_q;
    logic [IDX_W-1:0]             res_idx_q;

    logic w_match, w_valid, w_action;
    logic w_ack, w_eval, w_last;

    fw_rule_match #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_match (
        .rule_i     (rd_0_data),
        .key_ip_i   (key_ip_q),
        .key_port_i (key_port_q),
        .match_o    (w_match),
        .valid_o    (w_valid),
        .action_o   (w_action)
    );

    // Data is only trusted while a read of ours is outstanding; stale vld is dropped.
    assign w_ack  = (state_q == ISSUE) && req_q && rd_0_ack;
    assign w_eval = (w_ack && rd_0_vld) || ((state_q == WAIT_VLD) && rd_0_vld);
    assign w_last = (index_q == IDX_W'(NUM_RULES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            key_ip_q   <= 32'd0;
            key_port_q <= 16'd0;
            index_q    <= '0;
            wd_q       <= '0;
            rdy_q      <= 1'b1;
            req_q      <= 1'b0;
            addr_q     <= '0;
            v_drop_q   <= 1'b0;
            v_hit_q    <= 1'b0;
            v_to_q     <= 1'b0;
            v_idx_q    <= '0;
            res_vld_q  <= 1'b0;
            res_drop_q <= 1'b0;
            res_hit_q  <= 1'b0;
            res_to_q   <= 1'b0;
            res_idx_q  <= '0;
        end else begin
            res_vld_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (lookup_req) begin
                        key_ip_q   <= lookup_ip;
                        key_port_q <= lookup_port;
                        index_q    <= '0;
                        wd_q       <= '0;
                        addr_q     <= RULE_BASE;
                        rdy_q      <= 1'b0;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE, WAIT_VLD: begin
                    if (w_eval) begin
                        req_q <= 1'b0;
                        wd_q  <= '0;
                        if (w_match) begin
                            v_drop_q <= (w_action == ACTION_DROP);
                            v_hit_q  <= 1'b1;
                            v_idx_q  <= index_q;
                            v_to_q   <= 1'b0;
                            state_q  <= DONE;
                        end else if (!w_valid || w_last) begin
                            v_drop_q <= 1'b0;
                            v_hit_q  <= 1'b0;
                            v_idx_q  <= '0;
                            v_to_q   <= 1'b0;
                            state_q  <= DONE;
                        end else begin
                            index_q <= index_q + IDX_W'(1);
                            addr_q  <= addr_q + SRAM_ADDR_WIDTH'(1);
                            state_q <= ISSUE;
                        end
                    end else if (w_ack) begin
                        req_q   <= 1'b0;
                        wd_q    <= '0;
                        state_q <= WAIT_VLD;
                    end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        // Fail open: a stuck SRAM must not black-hole traffic.
                        req_q    <= 1'b0;
                        v_drop_q <= 1'b0;
                        v_hit_q  <= 1'b0;
                        v_idx_q  <= '0;
                        v_to_q   <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        wd_q <= wd_q + WD_W'(1);
                        if (state_q == ISSUE) begin
                            req_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    res_vld_q  <= 1'b1;
                    res_drop_q <= v_drop_q;
                    res_hit_q  <= v_hit_q;
                    res_idx_q  <= v_idx_q;
                    res_to_q   <= v_to_q;
                    rdy_q      <= 1'b1;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign lookup_rdy     = rdy_q;
    assign rd_0_req       = req_q;
    assign rd_0_addr      = addr_q;
    assign result_vld     = res_vld_q;
    assign result_drop    = res_drop_q;
    assign result_hit     = res_hit_q;
    assign result_idx     = res_idx_q;
    assign result_timeout = res_to_q;

endmodule

`default_nettype wire

// File: tb/tb_fw_rule_lookup.sv
// ============================================================================
// tb_fw_rule_lookup: directed scenarios against a small SRAM responder model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fw_rule_lookup;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        lookup_req = 1'b0;
    logic [31:0] lookup_ip = 32'd0;
    logic [15:0] lookup_port = 16'd0;
    logic        lookup_rdy;
    logic        result_vld, result_drop, result_hit, result_timeout;
    logic [3:0]  result_idx;
    logic        rd_0_req;
    logic [18:0] rd_0_addr;
    logic        rd_0_ack, rd_0_vld;
    logic [63:0] rd_0_data;

    logic        ack_en = 1'b1;
    logic        vld_en = 1'b1;
    logic        late_vld = 1'b0;
    logic [63:0] mem [0:7];

    int vectors = 0;
    int miscompares = 0;
    int reads = 0;
    int addr5_cnt = 0;
    logic [18:0] last_addr = 19'd0;

    always #5 clk = ~clk;

    fw_rule_lookup dut (
        .clk            (clk),
        .reset          (reset),
        .lookup_req     (lookup_req),
        .lookup_ip      (lookup_ip),
        .lookup_port    (lookup_port),
        .lookup_rdy     (lookup_rdy),
        .result_vld     (result_vld),
        .result_drop    (result_drop),
        .result_hit     (result_hit),
        .result_idx     (result_idx),
        .result_timeout (result_timeout),
        .rd_0_req       (rd_0_req),
        .rd_0_addr      (rd_0_addr),
        .rd_0_ack       (rd_0_ack),
        .rd_0_data      (rd_0_data),
        .rd_0_vld       (rd_0_vld)
    );

    // Zero-wait SRAM: ack and data in the request cycle unless withheld.
    assign rd_0_ack  = rd_0_req & ack_en;
    assign rd_0_vld  = (rd_0_ack & vld_en) | late_vld;
    assign rd_0_data = mem[rd_0_addr[2:0]];

    always @(posedge clk) begin
        if (!reset && rd_0_req && rd_0_ack) begin
            reads     <= reads + 1;
            last_addr <= rd_0_addr;
        end
        if (rd_0_req && rd_0_addr == 19'd5) addr5_cnt <= addr5_cnt + 1;
    end

    task automatic load_basic();
        for (int i = 0; i < 8; i++) mem[i] = 64'd0;
        mem[0] = 64'h8000_0016_0A00_0001;  // valid, pass, port 22, ip 10.0.0.1
        mem[1] = 64'hC000_0050_0000_0000;  // valid, drop, port 80, ip any
        mem[2] = 64'h8000_0000_C0A8_0101;  // valid, pass, port any, ip 192.168.1.1
    endtask

    task automatic run_lookup(input logic [31:0] ip, input logic [15:0] port, output int lat);
        int n;
        @(negedge clk);
        lookup_req  = 1'b1;
        lookup_ip   = ip;
        lookup_port = port;
        n = 0;
        while (!lookup_rdy && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 lookup_req = 1'b0;
        lat = 0;
        while (lat < 300) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (result_vld) break;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        vectors++; if (lookup_rdy !== 1'b1) begin miscompares++; $display("FAIL reset_rdy got=%b exp=1", lookup_rdy); end
        vectors++; if (rd_0_req !== 1'b0) begin miscompares++; $display("FAIL reset_req got=%b exp=0", rd_0_req); end
        vectors++; if (rd_0_addr !== 19'd0) begin miscompares++; $display("FAIL reset_addr got=%h exp=0", rd_0_addr); end
        vectors++; if ({result_vld, result_drop, result_hit, result_idx, result_timeout} !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_result got=%b%b%b%h%b exp=all zero", result_vld, result_drop, result_hit, result_idx, result_timeout);
        end
    endtask

    task automatic test_hit_drop();
        int lat;
        load_basic();
        run_lookup(32'h0A00_0009, 16'd80, lat);
        vectors++; if (lat !== 5) begin miscompares++; $display("FAIL hit_latency got=%0d exp=5", lat); end
        vectors++; if (result_drop !== 1'b1) begin miscompares++; $display("FAIL hit_drop got=%b exp=1", result_drop); end
        vectors++; if (result_hit !== 1'b1) begin miscompares++; $display("FAIL hit_hit got=%b exp=1", result_hit); end
        vectors++; if (result_idx !== 4'd1) begin miscompares++; $display("FAIL hit_idx got=%0d exp=1", result_idx); end
        vectors++; if (result_timeout !== 1'b0) begin miscompares++; $display("FAIL hit_timeout got=%b exp=0", result_timeout); end
    endtask

    task automatic test_end_of_table();
        int lat, r0;
        load_basic();
        mem[0] = 64'h0000_0016_0A00_0001;  // valid bit clear
        mem[1] = 64'hC000_0000_0000_0000;  // would match anything if reached
        r0 = reads;
        run_lookup(32'h0A00_0001, 16'd22, lat);
        vectors++; if (reads - r0 !== 1) begin miscompares++; $display("FAIL eot_reads got=%0d exp=1", reads - r0); end
        vectors++; if (lat !== 3) begin miscompares++; $display("FAIL eot_latency got=%0d exp=3", lat); end
        vectors++; if ({result_drop, result_hit, result_idx} !== 6'd0) begin
            miscompares++; $display("FAIL eot_verdict got=%b%b%0d exp=pass,nohit,0", result_drop, result_hit, result_idx);
        end
    endtask

    task automatic test_full_scan();
        int lat, r0, a0;
        logic [63:0] w;
        for (int i = 0; i < 8; i++) mem[i] = 64'd0;
        for (int i = 0; i < 5; i++) begin
            w = {1'b1, 1'b0, 14'd0, 16'(i + 1), 32'h0102_0304};
            mem[i] = w;
        end
        mem[5] = 64'hC000_0000_0000_0000;
        r0 = reads;
        a0 = addr5_cnt;
        run_lookup(32'h0A00_0009, 16'd80, lat);
        vectors++; if (reads - r0 !== 5) begin miscompares++; $display("FAIL scan_reads got=%0d exp=5", reads - r0); end
        vectors++; if (last_addr !== 19'd4) begin miscompares++; $display("FAIL scan_last_addr got=%0d exp=4", last_addr); end
        vectors++; if (addr5_cnt - a0 !== 0) begin miscompares++; $display("FAIL scan_addr5 got=%0d exp=0", addr5_cnt - a0); end
        vectors++; if (lat !== 11) begin miscompares++; $display("FAIL scan_latency got=%0d exp=11", lat); end
        vectors++; if ({result_drop, result_hit, result_idx, result_timeout} !== 7'd0) begin
            miscompares++; $display("FAIL scan_verdict got=%b%b%0d%b exp=pass,nohit,0,0", result_drop, result_hit, result_idx, result_timeout);
        end
    endtask

    task automatic test_timeout();
        int lat, pulses;
        load_basic();
        vld_en = 1'b0;
        run_lookup(32'h0A00_0009, 16'd80, lat);
        vectors++; if (lat !== 67) begin miscompares++; $display("FAIL to_latency got=%0d exp=67", lat); end
        vectors++; if (result_timeout !== 1'b1) begin miscompares++; $display("FAIL to_flag got=%b exp=1", result_timeout); end
        vectors++; if ({result_drop, result_hit} !== 2'b00) begin
            miscompares++; $display("FAIL to_verdict got=%b%b exp=00", result_drop, result_hit);
        end
        repeat (10) @(negedge clk);
        late_vld = 1'b1;
        @(negedge clk);
        late_vld = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (result_vld) pulses++;
        end
        vectors++; if (pulses !== 0) begin miscompares++; $display("FAIL to_late_vld got=%0d pulses exp=0", pulses); end
        vectors++; if (result_timeout !== 1'b1) begin miscompares++; $display("FAIL to_hold got=%b exp=1", result_timeout); end
    endtask

    task automatic test_reset_mid();
        int lat, pulses;
        load_basic();
        vld_en = 1'b0;
        @(negedge clk);
        lookup_req  = 1'b1;
        lookup_ip   = 32'h0A00_0009;
        lookup_port = 16'd80;
        @(posedge clk);
        #1 lookup_req = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        vectors++; if (rd_0_req !== 1'b0) begin miscompares++; $display("FAIL rst_mid_req got=%b exp=0", rd_0_req); end
        vectors++; if (lookup_rdy !== 1'b1) begin miscompares++; $display("FAIL rst_mid_rdy got=%b exp=1", lookup_rdy); end
        vectors++; if ({result_vld, result_timeout} !== 2'b00) begin
            miscompares++; $display("FAIL rst_mid_result got=%b%b exp=00", result_vld, result_timeout);
        end
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (result_vld) pulses++;
        end
        vectors++; if (pulses !== 0) begin miscompares++; $display("FAIL rst_mid_pulse got=%0d exp=0", pulses); end
        vld_en = 1'b1;
        run_lookup(32'h0A00_0009, 16'd80, lat);
        vectors++; if (lat !== 5) begin miscompares++; $display("FAIL rst_after_latency got=%0d exp=5", lat); end
        vectors++; if ({result_drop, result_hit, result_idx} !== 6'b11_0001) begin
            miscompares++; $display("FAIL rst_after_verdict got=%b%b%0d exp=1,1,1", result_drop, result_hit, result_idx);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, acc_b, res_a, res_b, pulses;
        logic drop_pending;
        load_basic();
        @(negedge clk);
        lookup_req  = 1'b1;
        lookup_ip   = 32'h0A00_0009;
        lookup_port = 16'd80;
        @(posedge clk);
        #1;
        lookup_ip   = 32'hC0A8_0101;
        lookup_port = 16'd22;
        cyc = 0; acc_b = -1; res_a = -1; res_b = -1; pulses = 0; drop_pending = 1'b0;
        while (cyc < 60) begin
            @(posedge clk);
            cyc++;
            if (drop_pending) begin
                #1 lookup_req = 1'b0;
                drop_pending = 1'b0;
            end
            @(negedge clk);
            if (result_vld) begin
                pulses++;
                if (res_a < 0) begin
                    res_a = cyc;
                    vectors++; if ({result_drop, result_hit, result_idx} !== 6'b11_0001) begin
                        miscompares++; $display("FAIL b2b_a_verdict got=%b%b%0d exp=1,1,1", result_drop, result_hit, result_idx);
                    end
                end else begin
                    res_b = cyc;
                    vectors++; if ({result_drop, result_hit, result_idx} !== 6'b01_0010) begin
                        miscompares++; $display("FAIL b2b_b_verdict got=%b%b%0d exp=0,1,2", result_drop, result_hit, result_idx);
                    end
                end
            end
            if (lookup_rdy && lookup_req && acc_b < 0) begin
                acc_b = cyc + 1;
                drop_pending = 1'b1;
            end
        end
        vectors++; if (res_a !== 5) begin miscompares++; $display("FAIL b2b_a_cycle got=%0d exp=5", res_a); end
        vectors++; if (acc_b !== 6) begin miscompares++; $display("FAIL b2b_accept got=%0d exp=6", acc_b); end
        vectors++; if (res_b !== 13) begin miscompares++; $display("FAIL b2b_b_cycle got=%0d exp=13", res_b); end
        vectors++; if (pulses !== 2) begin miscompares++; $display("FAIL b2b_pulses got=%0d exp=2", pulses); end
    endtask

    initial begin
        load_basic();
        test_reset();
        test_hit_drop();
        test_end_of_table();
        test_full_scan();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
